// File: rtl/spi_slave_sequencer.sv
// -----------------------------------------------------------------------------
// spi_slave_sequencer
//
// Sequences the 16-bit SPI-slave shift datapath from the system clock domain.
// Each chip-select frame starts with a command word:
//   bit 15     : 1 = burst read, 0 = burst write
//   bits 14:8  : start register address A
//   bits 7:0   : word count minus one (N = 1..256)
// Writes are issued as one reg_we strobe per received data word.
// Reads are prefetched one word ahead, and each value is handed to the
// serializer at the next word boundary.
//
// Ports
//   clock, rstb          system clock, asynchronous active-low reset
//   spi_sck, spi_csn     raw SPI clock (mode 3) and chip select (active low)
//   rx_word, rx_done     deserializer word and its word-complete level
//   tx_word, tx_next     word offered to the serializer and its load request
//   reg_addr, reg_wdata  register bank address / write data
//   reg_we, reg_re       one-cycle write / read strobes
//   reg_rdata            read data, valid one clock after reg_re
//   busy                 synchronized chip select is low
//   overrun              sticky: words arrived after the burst was exhausted
//   fsm_state            current sequencer state (debug visibility)
// -----------------------------------------------------------------------------
module spi_slave_sequencer #(
    parameter int          ADDR_W      = 7,
    parameter logic [15:0] IDLE_WORD   = 16'h5A5A,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              rstb,
    input  logic              spi_sck,
    input  logic              spi_csn,
    input  logic [15:0]       rx_word,
    input  logic              rx_done,
    output logic [15:0]       tx_word,
    output logic              tx_next,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [15:0]       reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [15:0]       reg_rdata,
    output logic              busy,
    output logic              overrun,
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------
    // Synchronizers and registered edge pulses. SCK and CSN reset to their
    // idle-high levels so that leaving reset never looks like an edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sh;
    logic [SYNC_STAGES-1:0] csn_sh;
    logic [SYNC_STAGES-1:0] done_sh;
    logic sck_s, csn_s, done_s;
    logic sck_d, csn_d, done_d;
    logic sck_fall, csn_fall, done_rise;

    assign sck_s  = sck_sh[SYNC_STAGES-1];
    assign csn_s  = csn_sh[SYNC_STAGES-1];
    assign done_s = done_sh[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge rstb) begin
        if (!rstb) begin
            sck_sh    <= '1;
            csn_sh    <= '1;
            done_sh   <= '0;
            sck_d     <= 1'b1;
            csn_d     <= 1'b1;
            done_d    <= 1'b0;
            sck_fall  <= 1'b0;
            csn_fall  <= 1'b0;
            done_rise <= 1'b0;
        end else begin
            sck_sh    <= {sck_sh[SYNC_STAGES-2:0], spi_sck};
            csn_sh    <= {csn_sh[SYNC_STAGES-2:0], spi_csn};
            done_sh   <= {done_sh[SYNC_STAGES-2:0], rx_done};
            sck_d     <= sck_s;
            csn_d     <= csn_s;
            done_d    <= done_s;
            sck_fall  <= sck_d & ~sck_s;
            csn_fall  <= csn_d & ~csn_s;
            // A done level that is high while the frame is closed (stale at
            // frame end) must never count as a word.
            done_rise <= done_s & ~done_d & ~csn_s;
        end
    end

    // ------------------------------------------------------------------
    // Burst bookkeeping
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        cnt_m1;     // count minus one, straight from the command
    logic [7:0]        idx;        // words serviced so far minus the current one
    logic [15:0]       pending;    // prefetched read data awaiting its boundary
    logic              rd_wait;    // reg_rdata is valid this clock
    logic              load_arm;   // raise tx_next on the next clock
    logic              last;

    assign last = (idx == cnt_m1);

    logic abort, do_cmd, do_write, do_load, do_idle_load, do_overrun;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        abort        = 1'b0;
        do_cmd       = 1'b0;
        do_write     = 1'b0;
        do_load      = 1'b0;
        do_idle_load = 1'b0;
        do_overrun   = 1'b0;
        if (state != S_IDLE && csn_s) begin
            // Chip select released: drop everything, no further strobes.
            abort      = 1'b1;
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (csn_fall) state_next = S_CMD;
                end
                S_CMD: begin
                    if (done_rise) begin
                        do_cmd       = 1'b1;
                        do_idle_load = 1'b1;   // frame word 1 is turnaround
                        state_next   = rx_word[15] ? S_READ : S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (done_rise) begin
                        do_write     = 1'b1;
                        do_idle_load = 1'b1;
                        if (last) state_next = S_DRAIN;
                    end
                end
                S_READ: begin
                    if (done_rise) begin
                        do_load = 1'b1;
                        if (last) state_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (done_rise) begin
                        do_overrun   = 1'b1;
                        do_idle_load = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serializer load handshake: tx_next is the request, the serializer's
    // SCK falling edge is the acceptance. tx_word is written one clock
    // before tx_next rises and is left alone until tx_next drops, which
    // happens on the first synchronized SCK fall seen inside the window.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rstb) begin
        if (!rstb) begin
            state     <= S_IDLE;
            tx_word   <= IDLE_WORD;
            tx_next   <= 1'b1;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            overrun   <= 1'b0;
            base_addr <= '0;
            cnt_m1    <= '0;
            idx       <= '0;
            pending   <= '0;
            rd_wait   <= 1'b0;
            load_arm  <= 1'b0;
        end else begin
            state    <= state_next;
            reg_we   <= 1'b0;
            reg_re   <= 1'b0;
            rd_wait  <= reg_re;
            load_arm <= do_load | do_idle_load;

            // An aborted read still lands here; it just never gets loaded.
            if (rd_wait) pending <= reg_rdata;

            if (csn_fall)        overrun <= 1'b0;
            else if (do_overrun) overrun <= 1'b1;

            if (do_cmd) begin
                base_addr <= rx_word[8 +: ADDR_W];
                cnt_m1    <= rx_word[7:0];
                idx       <= '0;
                if (rx_word[15]) begin
                    reg_re   <= 1'b1;
                    reg_addr <= rx_word[8 +: ADDR_W];
                end
            end

            if (do_write) begin
                reg_we    <= 1'b1;
                reg_addr  <= base_addr + ADDR_W'(idx);
                reg_wdata <= rx_word;
                if (!last) idx <= idx + 8'd1;
            end

            // Load word k (data for A+k-1) and prefetch A+k unless the
            // burst is exhausted. Address wraps at ADDR_W bits.
            if (do_load) begin
                tx_word <= pending;
                if (!last) begin
                    reg_re   <= 1'b1;
                    reg_addr <= base_addr + ADDR_W'(idx + 8'd1);
                    idx      <= idx + 8'd1;
                end
            end

            if (do_idle_load || abort) tx_word <= IDLE_WORD;

            if (abort || (state == S_IDLE && csn_s) || load_arm) tx_next <= 1'b1;
            else if (sck_fall)                                   tx_next <= 1'b0;
        end
    end

    assign busy      = ~csn_s;
    assign fsm_state = state;

endmodule

// File: tb/tb_spi_slave_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_sequencer
//
// Directed bench: an SPI master (mode 3, SCK = clock/16) drives frames, small
// models of the deserializer, serializer and register bank surround the DUT,
// and every outcome is compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_slave_sequencer;

    localparam int HALF = 8;   // clocks per SCK half period

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic rstb  = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT connections ----------------
    logic        spi_sck   = 1'b1;
    logic        spi_csn   = 1'b1;
    logic        mosi      = 1'b0;
    logic [15:0] rx_word   = 16'h0000;
    logic        rx_done   = 1'b0;
    logic [15:0] reg_rdata = 16'h0000;
    logic [15:0] tx_word;
    logic        tx_next;
    logic [6:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic        busy;
    logic        overrun;
    logic [2:0]  fsm_state;

    spi_slave_sequencer dut (
        .clock     (clock),
        .rstb      (rstb),
        .spi_sck   (spi_sck),
        .spi_csn   (spi_csn),
        .rx_word   (rx_word),
        .rx_done   (rx_done),
        .tx_word   (tx_word),
        .tx_next   (tx_next),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .overrun   (overrun),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] mem [128];
    logic [22:0] obs_wr_q[$];      // {addr, data} of every reg_we seen
    logic [15:0] ld_q[$];          // every word the serializer loaded
    logic [22:0] exp_q[$];         // expected writes
    logic [15:0] exp_ld_q[$];      // expected serializer loads
    int          wr_ptr = 0;
    int          ld_ptr = 0;
    int          re_cnt = 0;
    int          clash_cnt = 0;
    int          tn_err = 0;       // tx_next wrong at some SCK falling edge
    int          rx_cnt = 0;
    int          bitpos = 0;
    logic [15:0] rx_sh = 16'h0000;

    // ---------------- register bank model ----------------
    always @(posedge clock) begin
        if (reg_re) begin
            reg_rdata <= mem[reg_addr];
            re_cnt    <= re_cnt + 1;
        end
        if (reg_we) obs_wr_q.push_back({reg_addr, reg_wdata});
        if (reg_we && reg_re) clash_cnt <= clash_cnt + 1;
    end

    // ---------------- deserializer model (samples MOSI on SCK rise) --------
    always @(posedge spi_sck or posedge spi_csn) begin
        if (spi_csn) begin
            rx_cnt <= 0;
        end else begin
            rx_sh  <= {rx_sh[14:0], mosi};
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt == 7) rx_done <= 1'b0;
            if (rx_cnt == 15) begin
                rx_word <= {rx_sh[14:0], mosi};
                rx_done <= 1'b1;
                rx_cnt  <= 0;
            end
        end
    end

    // ---------------- serializer model (loads on SCK fall) ----------------
    // tx_next must be high at every word-boundary fall and low at all others.
    always @(negedge spi_sck or posedge spi_csn) begin
        if (spi_csn) begin
            bitpos <= 0;
        end else begin
            if (bitpos == 0) begin
                if (!tx_next) tn_err <= tn_err + 1;
                ld_q.push_back(tx_word);
            end else if (tx_next) begin
                tn_err <= tn_err + 1;
            end
            bitpos <= (bitpos == 15) ? 0 : bitpos + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        int i;
        logic [22:0] got;
        check({tag, "_count"}, obs_wr_q.size() - wr_ptr, exp_q.size());
        i = 0;
        while (exp_q.size() > 0) begin
            got = (wr_ptr < obs_wr_q.size()) ? obs_wr_q[wr_ptr] : 23'h7FFFFF;
            check($sformatf("%s[%0d]", tag, i), got, exp_q.pop_front());
            wr_ptr++;
            i++;
        end
        wr_ptr = obs_wr_q.size();
    endtask

    task automatic check_loads(input string tag);
        int i;
        logic [15:0] got;
        check({tag, "_count"}, ld_q.size() - ld_ptr, exp_ld_q.size());
        i = 0;
        while (exp_ld_q.size() > 0) begin
            got = (ld_ptr < ld_q.size()) ? ld_q[ld_ptr] : 16'hDEAD;
            check($sformatf("%s[%0d]", tag, i), got, exp_ld_q.pop_front());
            ld_ptr++;
            i++;
        end
        ld_ptr = ld_q.size();
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bits(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            wait_clks(HALF);
            spi_sck = 1'b0;
            mosi    = w[15-i];
            wait_clks(HALF);
            spi_sck = 1'b1;
        end
    endtask

    task automatic frame_begin();
        spi_csn = 1'b0;
    endtask

    task automatic frame_end();
        wait_clks(HALF);
        spi_csn = 1'b1;
        wait_clks(12);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_word"},   tx_word,   16'h5A5A);
        check({tag, "_tx_next"},   tx_next,   1);
        check({tag, "_reg_addr"},  reg_addr,  0);
        check({tag, "_reg_wdata"}, reg_wdata, 0);
        check({tag, "_reg_we"},    reg_we,    0);
        check({tag, "_reg_re"},    reg_re,    0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_overrun"},   overrun,   0);
        check({tag, "_state"},     fsm_state, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    int snap_tn;
    int snap_re;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[7'h7E] = 16'h1111;
        mem[7'h7F] = 16'h2222;
        mem[7'h00] = 16'h3333;
        mem[7'h40] = 16'hBEEF;
        mem[7'h41] = 16'hCAFE;

        wait_clks(4);
        rstb = 1'b1;
        wait_clks(4);
        check_reset_values("por");

        // Write burst: A=0x12, N=3
        snap_tn = tn_err;
        frame_begin();
        send_bits(16'h1202, 16);
        send_bits(16'hAAAA, 16);
        send_bits(16'hBBBB, 16);
        send_bits(16'hCCCC, 16);
        frame_end();
        exp_q.push_back({7'h12, 16'hAAAA});
        exp_q.push_back({7'h13, 16'hBBBB});
        exp_q.push_back({7'h14, 16'hCCCC});
        repeat (4) exp_ld_q.push_back(16'h5A5A);
        check_writes("wr_burst");
        check_loads("wr_miso");
        check("wr_overrun", overrun, 0);
        check("wr_tx_timing", tn_err - snap_tn, 0);

        // Read burst with address wrap: A=0x7E, N=3
        snap_tn = tn_err;
        snap_re = re_cnt;
        frame_begin();
        send_bits(16'hFE02, 16);
        repeat (4) send_bits(16'h0000, 16);
        frame_end();
        exp_ld_q.push_back(16'h5A5A);
        exp_ld_q.push_back(16'h5A5A);
        exp_ld_q.push_back(16'h1111);
        exp_ld_q.push_back(16'h2222);
        exp_ld_q.push_back(16'h3333);
        check_loads("rd_miso");
        check("rd_re_count", re_cnt - snap_re, 3);
        check_writes("rd_no_write");
        check("rd_tx_timing", tn_err - snap_tn, 0);

        // Overrun: write A=0x05, N=1, then two extra words
        frame_begin();
        send_bits(16'h0500, 16);
        send_bits(16'h0F0F, 16);
        send_bits(16'h1234, 16);
        send_bits(16'h5678, 16);
        frame_end();
        exp_q.push_back({7'h05, 16'h0F0F});
        repeat (4) exp_ld_q.push_back(16'h5A5A);
        check_writes("ovr_write");
        check_loads("ovr_miso");
        check("ovr_sticky", overrun, 1);

        // Abort: write A=0x30, N=4, csn released mid second data word
        frame_begin();
        wait_clks(6);
        check("abort_overrun_cleared", overrun, 0);
        check("abort_busy", busy, 1);
        send_bits(16'h3003, 16);
        send_bits(16'h1357, 16);
        send_bits(16'h2468, 8);
        frame_end();
        exp_q.push_back({7'h30, 16'h1357});
        check_writes("abort_write");
        check("abort_state", fsm_state, 0);
        check("abort_tx_next", tx_next, 1);
        check("abort_tx_word", tx_word, 16'h5A5A);
        check("abort_busy_end", busy, 0);

        // Reset in the middle of a read burst (A=0x40, N=2)
        frame_begin();
        send_bits(16'hC001, 16);
        send_bits(16'h0000, 16);
        send_bits(16'h0000, 8);
        wait_clks(3);
        rstb = 1'b0;
        #1;
        check_reset_values("midrst");
        wait_clks(2);
        spi_csn = 1'b1;
        wait_clks(4);
        rstb = 1'b1;
        wait_clks(6);
        ld_ptr = ld_q.size();
        wr_ptr = obs_wr_q.size();

        // Next frame after reset decodes cleanly
        snap_tn = tn_err;
        snap_re = re_cnt;
        frame_begin();
        send_bits(16'hC001, 16);
        repeat (3) send_bits(16'h0000, 16);
        frame_end();
        exp_ld_q.push_back(16'h5A5A);
        exp_ld_q.push_back(16'h5A5A);
        exp_ld_q.push_back(16'hBEEF);
        exp_ld_q.push_back(16'hCAFE);
        check_loads("post_rst_miso");
        check("post_rst_re_count", re_cnt - snap_re, 2);
        check("post_rst_tx_timing", tn_err - snap_tn, 0);

        check("strobe_clash", clash_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_sequencer.md
# spi_slave_sequencer

System-clock-domain controller that sequences the 16-bit SPI-slave shift datapath: the parallel-in/serial-out transmitter and the serial-in/parallel-out receiver. It decodes a command word per chip-select frame and runs burst register writes or reads against a 7-bit register file. It also decides exactly when the transmitter reloads. It sits between the SPI pins/shift registers and the register bank of the Doppler front-end.

## Interface
- ADDR_W, 7, register address width
- IDLE_WORD, 16'h5A5A, word shifted out when no read data is scheduled
- SYNC_STAGES, 2, synchronizer depth for spi_sck, spi_csn, rx_done (≥2)
- clock  in  1  system clock; must be ≥16× SCK frequency
- rstb  in  1  asynchronous active-low reset
- spi_sck  in  1  raw SPI clock (mode 3, idles high)
- spi_csn  in  1  raw chip select, active low
- rx_word  in  16  deserializer parallel word; stable for ≥15 SCK periods after rx_done rises
- rx_done  in  1  deserializer word-complete level (SCK domain)
- tx_word  out  16  parallel word to serializer
- tx_next  out  1  serializer load request (sampled by serializer at SCK falling edge)
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  16  register write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe; reg_rdata valid exactly 1 clock later
- reg_rdata  in  16  register read data
- busy  out  1  high while a frame is active (synced csn low)
- overrun  out  1  sticky: words received beyond burst count in current frame

## Operation
- spi_sck, spi_csn, rx_done pass through SYNC_STAGES flops; edges are detected on synced values (sck_fall, csn_fall, csn_rise, done_rise).
- Command word (frame word 0): bit15 RW (1=read), bits14:8 start address A, bits7:0 count−1 (N = 1..256 words).
- States: IDLE → CMD on csn_fall; CMD → WRITE or READ on done_rise; WRITE/READ → DRAIN when N words are serviced; any state → IDLE on csn_rise (abort, no further strobes).
- WRITE: each done_rise in WRITE drives reg_addr=A+i, reg_wdata=rx_word, reg_we=1 for one clock; i increments afterwards.
- READ: on entry, issue reg_re for A and capture reg_rdata into a pending buffer 1 clock later. Word 1 is turnaround (IDLE_WORD). At each word boundary k≥1, load pending data (addr A+k−1) into tx_word, then prefetch the next address. Data words occupy frame words 2..N+1. After N loads, tx_word=IDLE_WORD.
- Address arithmetic: ADDR_W bits, wraps 127→0. Count is 8 bits and exhaustion is exact, with no wrap.
- DRAIN: done_rise sets overrun and issues no strobes; tx_word=IDLE_WORD.
- overrun clears on csn_fall; busy = synced csn low.
- done_rise is ignored while synced csn is high, including a stale level at frame end.

## Timing
- Reset values: tx_word=IDLE_WORD, tx_next=1, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, overrun=0, state=IDLE.
- Load window rule: tx_next is raised (a) while idle with synced csn high, and (b) on the clock after done_rise in CMD/READ/DRAIN/WRITE. It drops on the first sck_fall detected inside the window. tx_word must be final before tx_next rises and stay stable until tx_next drops.
- Worst-case done_rise detection is SYNC_STAGES+1 clocks after the SCK rising edge. With clock ≥16× SCK this is inside the half-period before the serializer's load edge.
- Write strobe: reg_we asserts SYNC_STAGES+2 clocks after the SCK rising edge completing the word.
- Read prefetch completes within 3 clocks of the preceding load, well before the next boundary.
- At most one reg_we or reg_re per clock; never both.
- Abort: csn_rise forces IDLE within 1 clock. Pending reg_re completes silently, with no load. tx_word returns to IDLE_WORD with tx_next=1.

## Test plan
- Reset mid-operation: assert rstb low during a READ burst → all outputs at reset values next clock; next frame decodes correctly.
- Write burst: cmd 16'h1202 (write, A=0x12, N=3) then words 0xAAAA, 0xBBBB, 0xCCCC → reg_we pulses with addr 0x12/0x13/0x14 and matching data; overrun=0.
- Read burst: reg bank 0x7E=0x1111, 0x7F=0x2222, 0x00=0x3333; cmd 16'hFE02 → MISO words 0x5A5A, 0x5A5A, 0x1111, 0x2222, 0x3333 (wrap checked); exactly 3 reg_re pulses.
- Overrun: cmd 16'h0500 (write, N=1) plus 2 extra words → one reg_we at 0x05; overrun=1 until next csn_fall, then 0.
- Abort: csn deasserted after 8 bits of second data word in write burst → only first reg_we occurs; state IDLE, tx_next=1.
- Timing margin: SCK at exactly clock/16 → every tx_next drops only after an sck_fall and is never high across two SCK falling edges.
